pixel_fp32_sequencer: RTL and testbench

//  Time-shares one combinational byte->fp32 converter across the NUM_CH 8-bit channels of each pixel.

---
 rtl/pixel_fp32_pkg.sv | 14 +
 rtl/pixel_fp32_sequencer_conv.sv | 39 +++
 rtl/pixel_fp32_sequencer.sv | 89 ++++++++
 tb/tb_pixel_fp32_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_fp32_pkg.sv
// Shared types and constants for the pixel byte-to-fp32 sequencer.
package pixel_fp32_pkg;

  typedef enum logic {
    S_IDLE,
    S_CONV
  } state_t;

  typedef logic [1:0] ch_idx_t;

  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
  localparam logic [31:0] FP32_ONE  = 32'h3F80_0000;

endpackage

// File: rtl/pixel_fp32_sequencer_conv.sv
// Combinational byte -> fp32 converter producing round-to-nearest-even(x/255).
module pixel_fp32_sequencer_conv
  import pixel_fp32_pkg::*;
(
  input  logic [7:0]  i_uint8_int,
  output logic [31:0] o_fp32_hex
);

  logic [2:0]  lz;
  logic [30:0] pattern;
  logic [4:0]  top;
  logic [23:0] win;
  logic [7:0]  expo;

  always_comb begin
    lz = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (i_uint8_int[i]) lz = 3'(7 - i);
    end
  end

  // x/255 in binary is the byte x repeated forever, so the mantissa is a window
  // into that pattern just after the leading one; the infinite nonzero tail
  // rules out exact ties, so the guard bit alone decides rounding.
  assign pattern = {i_uint8_int[6:0], {3{i_uint8_int}}};
  assign top     = 5'd30 - {2'b00, lz};
  assign win     = pattern[top -: 24];
  assign expo    = 8'd126 - {5'b00000, lz};

  always_comb begin
    if (i_uint8_int == 8'h00)
      o_fp32_hex = FP32_ZERO;
    else if (i_uint8_int == 8'hFF)
      o_fp32_hex = FP32_ONE;
    else
      o_fp32_hex = {1'b0, expo, win[23:1]} + {31'b0, win[0]};
  end

endmodule

// File: rtl/pixel_fp32_sequencer.sv
// Time-shares one byte->fp32 converter across the channels of each accepted pixel,
// emitting one fp32 word per channel on a valid/ready stream.
module pixel_fp32_sequencer
  import pixel_fp32_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [8*NUM_CH-1:0]   i_pix,
  input  logic                  i_pix_last,
  input  logic                  i_pix_valid,
  output logic                  o_pix_ready,
  output logic [31:0]           o_fp32,
  output logic [1:0]            o_ch,
  output logic                  o_last,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_busy,
  output logic                  o_frame_done,
  output logic [CNT_W-1:0]      o_pix_cnt
);

  state_t                state;
  ch_idx_t               idx;
  logic [8*NUM_CH-1:0]   held_pix;
  logic                  held_last;
  logic                  load;
  logic                  last_idx;
  logic                  accept;
  logic [7:0]            conv_byte;
  logic [31:0]           conv_fp32;

  assign last_idx     = (idx == ch_idx_t'(NUM_CH - 1));
  assign load         = (state == S_CONV) && (!o_valid || i_ready);
  assign o_pix_ready  = !i_rst && ((state == S_IDLE) || (load && last_idx));
  assign accept       = i_pix_valid && o_pix_ready;
  assign o_frame_done = o_valid && i_ready && o_last;
  assign o_busy       = (state == S_CONV) || o_valid;

  always_comb begin
    conv_byte = held_pix[7:0];
    for (int k = 0; k < NUM_CH; k++) begin
      if (idx == ch_idx_t'(k)) conv_byte = held_pix[8*k +: 8];
    end
  end

  pixel_fp32_sequencer_conv u_conv (
    .i_uint8_int (conv_byte),
    .o_fp32_hex  (conv_fp32)
  );

  // A same-cycle accept is ordered after the load so that it overrides the
  // return to idle on the final channel, keeping back-to-back pixels bubble-free.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      held_pix  <= '0;
      held_last <= 1'b0;
      o_fp32    <= FP32_ZERO;
      o_ch      <= '0;
      o_last    <= 1'b0;
      o_valid   <= 1'b0;
      o_pix_cnt <= '0;
    end else begin
      if (load) begin
        o_fp32  <= conv_fp32;
        o_ch    <= idx;
        o_last  <= held_last && last_idx;
        o_valid <= 1'b1;
        idx     <= idx + 2'd1;
        if (last_idx) state <= S_IDLE;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end

      if (accept) begin
        held_pix  <= i_pix;
        held_last <= i_pix_last;
        idx       <= '0;
        state     <= S_CONV;
        o_pix_cnt <= o_pix_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pixel_fp32_sequencer.sv
// Scoreboard bench for pixel_fp32_sequencer: expected words are queued on pixel
// accept and compared as the DUT hands words off.
module tb_pixel_fp32_sequencer;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 16;

  typedef struct {
    logic [31:0] fp;
    logic [1:0]  ch;
    logic        last;
  } word_t;

  logic                i_clk;
  logic                i_rst;
  logic [8*NUM_CH-1:0] i_pix;
  logic                i_pix_last;
  logic                i_pix_valid;
  logic                o_pix_ready;
  logic [31:0]         o_fp32;
  logic [1:0]          o_ch;
  logic                o_last;
  logic                o_valid;
  logic                i_ready;
  logic                o_busy;
  logic                o_frame_done;
  logic [CNT_W-1:0]    o_pix_cnt;

  word_t       sb[$];
  int          num_checks = 0;
  int          num_errors = 0;
  int          exp_cnt = 0;
  int          handoffs = 0;
  int          frame_pulses = 0;
  int          cycle = 0;
  int          last_handoff = -1;
  bit          ready_level = 1'b1;
  bit          rand_mode = 1'b0;
  bit          tp_mode = 1'b0;
  bit          sweep_mode = 1'b0;
  bit          sweep_have_prev = 1'b0;
  logic [31:0] sweep_prev = '0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_fp32 = '0;
  logic [1:0]  prev_ch = '0;

  pixel_fp32_sequencer #(
    .NUM_CH (NUM_CH),
    .CNT_W  (CNT_W)
  ) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_pix        (i_pix),
    .i_pix_last   (i_pix_last),
    .i_pix_valid  (i_pix_valid),
    .o_pix_ready  (o_pix_ready),
    .o_fp32       (o_fp32),
    .o_ch         (o_ch),
    .o_last       (o_last),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_pix_cnt    (o_pix_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cycle <= cycle + 1;

  initial begin
    i_ready = 1'b1;
    forever begin
      @(posedge i_clk);
      #1;
      i_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_level;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_errors++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // Long-division reference: scale x until the quotient has 24 bits, then round.
  function automatic logic [31:0] conv_model(input logic [7:0] x);
    longint unsigned num, q, r;
    int k;
    if (x == 8'h00) return 32'h0000_0000;
    if (x == 8'hFF) return 32'h3F80_0000;
    k = 0;
    while (((64'(x) << k) / 255) < 64'(1 << 23)) k++;
    num = 64'(x) << k;
    q = num / 255;
    r = num % 255;
    if (2 * r > 255) q++;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      k--;
    end
    return {1'b0, 8'(150 - k), q[22:0]};
  endfunction

  task automatic applyStimulus(input logic [8*NUM_CH-1:0] pix, input logic last);
    int  waited = 0;
    bit  done = 1'b0;
    word_t w;
    i_pix       = pix;
    i_pix_last  = last;
    i_pix_valid = 1'b1;
    while (!done && waited < 200) begin
      @(negedge i_clk);
      if (o_pix_ready) begin
        for (int k = 0; k < NUM_CH; k++) begin
          w.fp   = conv_model(pix[8*k +: 8]);
          w.ch   = 2'(k);
          w.last = last && (k == NUM_CH - 1);
          sb.push_back(w);
        end
        exp_cnt++;
        done = 1'b1;
      end
      waited++;
      @(posedge i_clk);
      #1;
    end
    i_pix_valid = 1'b0;
    checkOutput("accept_in_time", 32'(done), 32'd1);
    checkOutput("pix_cnt", 32'(o_pix_cnt), 32'(exp_cnt[CNT_W-1:0]));
  endtask

  task automatic waitDrain();
    int w = 0;
    while ((sb.size() != 0 || o_busy) && w < 2000) begin
      @(posedge i_clk);
      #1;
      w++;
    end
    checkOutput("drain_in_time", 32'(w < 2000), 32'd1);
  endtask

  always @(negedge i_clk) begin
    word_t e;
    if (i_rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checkOutput("stall_valid", 32'(o_valid), 32'd1);
        checkOutput("stall_fp32", o_fp32, prev_fp32);
        checkOutput("stall_ch", 32'(o_ch), 32'(prev_ch));
      end
      if (o_valid && i_ready) begin
        checkOutput("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checkOutput("word_fp32", o_fp32, e.fp);
          checkOutput("word_ch", 32'(o_ch), 32'(e.ch));
          checkOutput("word_last", 32'(o_last), 32'(e.last));
          checkOutput("frame_done", 32'(o_frame_done), 32'(e.last));
        end
        if (tp_mode && last_handoff >= 0)
          checkOutput("tp_gap", 32'(cycle - last_handoff), 32'd1);
        last_handoff = cycle;
        if (sweep_mode && o_ch == 2'd0) begin
          if (sweep_have_prev)
            checkOutput("monotonic", 32'(o_fp32 > sweep_prev), 32'd1);
          sweep_prev      = o_fp32;
          sweep_have_prev = 1'b1;
        end
        handoffs++;
      end
      if (o_frame_done) frame_pulses++;
      prev_stall = o_valid && !i_ready;
      prev_fp32  = o_fp32;
      prev_ch    = o_ch;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int h0, f0, w;
    i_rst       = 1'b1;
    i_pix       = 24'h123456;
    i_pix_last  = 1'b0;
    i_pix_valid = 1'b1;

    // Reset held three cycles with a pixel offered: nothing accepted, all outputs zero.
    repeat (3) begin
      @(posedge i_clk);
      @(negedge i_clk);
      checkOutput("rst_pix_ready", 32'(o_pix_ready), 32'd0);
      checkOutput("rst_valid", 32'(o_valid), 32'd0);
      checkOutput("rst_busy", 32'(o_busy), 32'd0);
      checkOutput("rst_fp32", o_fp32, 32'd0);
      checkOutput("rst_ch", 32'(o_ch), 32'd0);
      checkOutput("rst_last", 32'(o_last), 32'd0);
      checkOutput("rst_frame_done", 32'(o_frame_done), 32'd0);
      checkOutput("rst_pix_cnt", 32'(o_pix_cnt), 32'd0);
    end
    @(posedge i_clk);
    #1;
    i_rst       = 1'b0;
    i_pix_valid = 1'b0;

    applyStimulus(24'hFF8000, 1'b0);
    waitDrain();

    tp_mode      = 1'b1;
    last_handoff = -1;
    h0           = handoffs;
    for (int p = 0; p < 4; p++) applyStimulus(24'($urandom), 1'b0);
    waitDrain();
    tp_mode = 1'b0;
    checkOutput("tp_words", 32'(handoffs - h0), 32'd12);

    rand_mode = 1'b1;
    for (int p = 0; p < 8; p++) applyStimulus(24'($urandom), 1'b0);
    waitDrain();
    rand_mode = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;

    f0 = frame_pulses;
    applyStimulus(24'h40C0_11, 1'b1);
    waitDrain();
    checkOutput("frame_pulses", 32'(frame_pulses - f0), 32'd1);

    // Reset while channel 2 sits stalled; it must never reach the output.
    applyStimulus(24'hA55AC3, 1'b1);
    w = 0;
    do begin
      @(negedge i_clk);
      w++;
    end while (!(o_valid && o_ch == 2'd1 && i_ready) && w < 50);
    checkOutput("ch1_seen", 32'(w < 50), 32'd1);
    ready_level = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    sb.delete();
    @(negedge i_clk);
    checkOutput("midrst_busy", 32'(o_busy), 32'd0);
    checkOutput("midrst_valid", 32'(o_valid), 32'd0);
    checkOutput("midrst_frame_done", 32'(o_frame_done), 32'd0);
    @(posedge i_clk);
    #1;
    i_rst       = 1'b0;
    exp_cnt     = 0;
    ready_level = 1'b1;
    applyStimulus(24'h336699, 1'b0);
    waitDrain();

    sweep_mode      = 1'b1;
    sweep_have_prev = 1'b0;
    for (int x = 0; x < 256; x++) applyStimulus({16'h7F01, 8'(x)}, 1'b0);
    waitDrain();
    sweep_mode = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule
